ahb_lite_bus_n: RTL and testbench
=================================

Name: ahb_lite_bus_n

Overview:
- Parametrised AHB-lite interconnect: one master, NS slaves.
- Decodes an address field to one-hot HSEL and registers the data-phase owner.
- Multiplexes HRDATA/HREADY/HRESP back to the master.
- Adds two blocks of new behaviour: a built-in default slave (two-cycle ERROR on unmapped accesses) and a wait-state watchdog (forced ERROR plus interrupt on a hung slave).

Parameters:
- NS, 6: number of slaves, 1..16.
- DW, 32: data width.
- DEC_HI, 31: MSB of the decoded address field.
- DEC_LO, 24: LSB of the decoded address field.
- SLV_BASE, {NS{8'h00}}: flattened NS x (DEC_HI-DEC_LO+1) match values; slave i occupies slice i.
- TIMEOUT, 255: maximum consecutive wait cycles per data phase; 0 disables the watchdog.

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- HREADY  out  1  bus ready, driven to the master and to all slaves.
- HRDATA  out  DW  read data to the master.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HSEL  out  NS  one-hot address-phase select.
- HREADY_S  in  NS  per-slave HREADYOUT.
- HRDATA_S  in  NS*DW  per-slave read data; slave i occupies slice i.
- HRESP_S  in  NS  per-slave HRESP.
- timeout_irq  out  1  one-cycle pulse when the watchdog fires.
- err_addr  out  32  address of the last ERROR-terminated transfer.
- err_src  out  1  0=unmapped access, 1=timeout; valid with err_addr.

Behaviour:
- Decode (combinational): HSEL[i] = (HADDR[DEC_HI:DEC_LO] == SLV_BASE slice i). HSEL is not gated by HTRANS.
- Overlapping matches: the lowest index wins; HSEL stays one-hot.
- Unmapped: no match and HTRANS[1]=1 selects the default slave.
- Data-phase owner register:
  - Loaded on every edge where HREADY=1.
  - Values: NONE, SLV(i), or DEF.
  - Loaded with NONE when HTRANS[1]=0.
  - The data-phase address is captured alongside it.
- Response mux by owner:
  - NONE: HREADY=1, HRESP=0, HRDATA=0.
  - SLV(i): HREADY=HREADY_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S slice i.
  - DEF: HRDATA=0.
- Default/forced-error FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1: on the edge where DEF is loaded, or when the watchdog fires.
  - ERR1 outputs HREADY=0, HRESP=1.
  - ERR1 -> ERR2 unconditionally; ERR2 outputs HREADY=1, HRESP=1.
  - ERR2 -> IDLE, with the owner reloaded from the current address phase.
  - ERR1/ERR2 override the response mux.
- Watchdog:
  - Counter clears whenever HREADY=1.
  - Otherwise it increments while the owner is SLV(i) and the FSM is IDLE.
  - When the count reaches TIMEOUT (TIMEOUT>0), on the next edge: FSM -> ERR1, timeout_irq=1 for exactly one cycle, err_addr=captured address, err_src=1.
  - The hung slave's late HREADY_S/HRDATA_S are ignored once in ERR1/ERR2.
  - Recovering the hung slave is software's responsibility; the watchdog is diagnostic plus bus-release.
- Unmapped access error recording: err_addr=captured address, err_src=0, updated on entry to ERR1; no interrupt.
- Latency:
  - Zero added cycles for mapped slaves (combinational return path).
  - Exactly 2 cycles for DEF.
  - TIMEOUT+3 cycles total for a hung slave (TIMEOUT wait cycles, the firing edge, ERR1, ERR2).
- Reset (synchronous, dominates all other events on the same edge):
  - Owner=NONE, FSM=IDLE, counter=0.
  - HREADY=1, HRESP=0, HRDATA=0.
  - timeout_irq=0, err_addr=0, err_src=0.
  - Reset mid-wait or mid-ERR abandons the transfer; the next cycle is an idle data phase.
- Back-to-back: the address phase of transfer N+1 overlaps the data phase of N. HSEL follows HADDR every cycle; the owner updates only when HREADY=1.
- Counter width is $clog2(TIMEOUT+1); the count saturates and never wraps.

Test Plan:
- Mapped read, NS=6, SLV_BASE slice 2=8'h40:
  - Stimulus: HADDR=32'h4000_0010, HTRANS=2'b10; next cycle slave 2 drives HRDATA_S=32'hCAFE_F00D, HREADY_S[2]=1.
  - Required: HSEL=6'b000100; HRDATA=32'hCAFE_F00D and HRESP=0 in the data phase, no added wait.
- Unmapped access:
  - Stimulus: HADDR=32'hF000_0000, HTRANS=2'b10.
  - Required: HSEL=0; data phase gives HREADY=0/HRESP=1, then HREADY=1/HRESP=1; err_addr=32'hF000_0000, err_src=0, timeout_irq stays 0.
- Hung slave, TIMEOUT=4:
  - Stimulus: slave 1 holds HREADY_S[1]=0 indefinitely.
  - Required: 4 wait cycles; on the next edge timeout_irq pulses one cycle with err_src=1; ERR1 then ERR2; the bus returns to IDLE 7 cycles after the data phase began.
- Pipelined mixed traffic:
  - Stimulus: write to slave 0 (1 wait state), immediately followed by a read to slave 3.
  - Required: slave 3 HSEL is held through the slave 0 wait; the owner switches only on the HREADY=1 edge; the read data is correct.
- Reset mid-ERR1:
  - Stimulus: assert HRESET during ERR1 of an unmapped access.
  - Required: next cycle HREADY=1, HRESP=0, err_addr=0, FSM IDLE.
- Watchdog disabled:
  - Stimulus: TIMEOUT=0, slave held not-ready for 1000 cycles.
  - Required: no timeout_irq, and HREADY remains 0 throughout.

Source files
------------

// File: rtl/ahb_lite_bus_n.sv
// ahb_lite_bus_n: AHB-lite interconnect for one master and NS slaves.
//
// The address field HADDR[DEC_HI:DEC_LO] is decoded to a one-hot HSEL. When
// several slaves match, the lowest index wins. The owner of the data phase is
// registered on every HREADY=1 edge, and HRDATA/HREADY/HRESP are multiplexed
// back to the master from that owner.
//
// Two extra functions are built in:
//   * a default slave that answers unmapped accesses with a two-cycle ERROR;
//   * a wait-state watchdog that forces a two-cycle ERROR, and pulses
//     timeout_irq, when a slave holds HREADY low for TIMEOUT cycles.
//
// Ports:
//   HCLK, HRESET         clock; synchronous active-high reset
//   HADDR, HTRANS        master address-phase signals
//   HREADY, HRDATA,      response to the master (HREADY also goes to the slaves)
//   HRESP
//   HSEL                 one-hot slave select; not gated by HTRANS
//   HREADY_S, HRDATA_S,  per-slave responses; slave i occupies slice i
//   HRESP_S
//   timeout_irq          one-cycle pulse when the watchdog fires
//   err_addr, err_src    address and cause of the last ERROR-terminated
//                        transfer (err_src: 0 = unmapped, 1 = timeout)
module ahb_lite_bus_n #(
  parameter int NS      = 6,
  parameter int DW      = 32,
  parameter int DEC_HI  = 31,
  parameter int DEC_LO  = 24,
  parameter logic [NS*(DEC_HI-DEC_LO+1)-1:0] SLV_BASE = '0,
  parameter int TIMEOUT = 255
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic             HREADY,
  output logic [DW-1:0]    HRDATA,
  output logic             HRESP,
  output logic [NS-1:0]    HSEL,
  input  logic [NS-1:0]    HREADY_S,
  input  logic [NS*DW-1:0] HRDATA_S,
  input  logic [NS-1:0]    HRESP_S,
  output logic             timeout_irq,
  output logic [31:0]      err_addr,
  output logic             err_src
);

  localparam int FW = DEC_HI - DEC_LO + 1;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  // The counter keeps at least one bit so that TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_SLV = 2'd1, OWN_DEF = 2'd2} owner_e;

  state_e          state_q, state_d;
  owner_e          own_q, own_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            irq_q, irq_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic            err_src_q, err_src_d;

  logic            hit_s;
  logic [IW-1:0]   hit_idx_s;
  logic            match_s;
  logic            def_s;
  logic            fire_s;
  logic            unused_s;

  assign unused_s = HTRANS[0];

  // Priority decode: the first matching slice claims HSEL; later matches are masked.
  always_comb begin
    HSEL      = '0;
    hit_s     = 1'b0;
    hit_idx_s = '0;
    match_s   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      match_s   = (HADDR[DEC_HI:DEC_LO] == SLV_BASE[i*FW +: FW]);
      HSEL[i]   = match_s & ~hit_s;
      hit_idx_s = (match_s && !hit_s) ? IW'(i) : hit_idx_s;
      hit_s     = hit_s | match_s;
    end
  end

  // Response mux; the error states override whatever the owner is driving.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (state_q)
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        case (own_q)
          OWN_SLV: begin
            HREADY = HREADY_S[idx_q];
            HRESP  = HRESP_S[idx_q];
            HRDATA = HRDATA_S[int'(idx_q)*DW +: DW];
          end
          default: begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = '0;
          end
        endcase
      end
    endcase
  end

  // The watchdog fires when the count has reached TIMEOUT and the slave is still stalling.
  assign def_s  = HTRANS[1] & ~hit_s;
  assign fire_s = (TIMEOUT > 0) && (state_q == ST_IDLE) && (own_q == OWN_SLV) &&
                  !HREADY && (cnt_q == TMO);

  // Next-state logic: owner/address capture, watchdog count, and the error FSM.
  always_comb begin
    own_d      = HREADY ? (!HTRANS[1] ? OWN_NONE : (hit_s ? OWN_SLV : OWN_DEF)) : own_q;
    idx_d      = HREADY ? hit_idx_s : idx_q;
    addr_d     = HREADY ? HADDR : addr_q;
    // The count saturates at TIMEOUT and never wraps.
    cnt_d      = HREADY ? '0 :
                 ((state_q == ST_IDLE) && (own_q == OWN_SLV) && (cnt_q != TMO)) ?
                 cnt_q + 1'b1 : cnt_q;
    state_d    = state_q;
    irq_d      = 1'b0;
    err_addr_d = err_addr_q;
    err_src_d  = err_src_q;
    case (state_q)
      ST_IDLE: begin
        if (HREADY && def_s) begin
          state_d    = ST_ERR1;
          err_addr_d = HADDR;
          err_src_d  = 1'b0;
        end else if (fire_s) begin
          state_d    = ST_ERR1;
          irq_d      = 1'b1;
          err_addr_d = addr_q;
          err_src_d  = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        // HREADY is high here, so the owner reloads; an unmapped follow-on goes straight back to ERR1.
        if (def_s) begin
          state_d    = ST_ERR1;
          err_addr_d = HADDR;
          err_src_d  = 1'b0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; the synchronous reset dominates every other event.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      own_q      <= OWN_NONE;
      idx_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
      err_addr_q <= '0;
      err_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
      err_addr_q <= err_addr_d;
      err_src_q  <= err_src_d;
    end
  end

  assign timeout_irq = irq_q;
  assign err_addr    = err_addr_q;
  assign err_src     = err_src_q;

endmodule

// File: tb/tb_ahb_lite_bus_n.sv
module tb_ahb_lite_bus_n;

  logic         hclk = 1'b0;
  logic         hreset;
  always #5 hclk = ~hclk;

  // DUT A: six slaves, TIMEOUT=4; slaves 4 and 5 overlap at 8'h80.
  logic [31:0]  a_haddr;
  logic [1:0]   a_htrans;
  logic         a_hready, a_hresp, a_irq, a_err_src;
  logic [31:0]  a_hrdata, a_err_addr;
  logic [5:0]   a_hsel, a_hready_s, a_hresp_s;
  logic [191:0] a_hrdata_s;

  // DUT B: two slaves, watchdog disabled.
  logic [31:0]  b_haddr;
  logic [1:0]   b_htrans;
  logic         b_hready, b_hresp, b_irq, b_err_src;
  logic [31:0]  b_hrdata, b_err_addr;
  logic [1:0]   b_hsel, b_hready_s, b_hresp_s;
  logic [63:0]  b_hrdata_s;

  ahb_lite_bus_n #(.NS(6), .DW(32), .DEC_HI(31), .DEC_LO(24),
                   .SLV_BASE(48'h80_80_60_40_20_00), .TIMEOUT(4)) u_dut_a (
    .HCLK(hclk), .HRESET(hreset), .HADDR(a_haddr), .HTRANS(a_htrans),
    .HREADY(a_hready), .HRDATA(a_hrdata), .HRESP(a_hresp), .HSEL(a_hsel),
    .HREADY_S(a_hready_s), .HRDATA_S(a_hrdata_s), .HRESP_S(a_hresp_s),
    .timeout_irq(a_irq), .err_addr(a_err_addr), .err_src(a_err_src));

  ahb_lite_bus_n #(.NS(2), .DW(32), .DEC_HI(31), .DEC_LO(24),
                   .SLV_BASE(16'h20_00), .TIMEOUT(0)) u_dut_b (
    .HCLK(hclk), .HRESET(hreset), .HADDR(b_haddr), .HTRANS(b_htrans),
    .HREADY(b_hready), .HRDATA(b_hrdata), .HRESP(b_hresp), .HSEL(b_hsel),
    .HREADY_S(b_hready_s), .HRDATA_S(b_hrdata_s), .HRESP_S(b_hresp_s),
    .timeout_irq(b_irq), .err_addr(b_err_addr), .err_src(b_err_src));

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pop the expected completion and compare it with DUT A's response.
  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_hready"}, 64'(a_hready), 64'd1);
      chk({tag, "_hrdata"}, 64'(a_hrdata), 64'(e.rdata));
      chk({tag, "_hresp"},  64'(a_hresp),  64'(e.resp));
    end
  endtask

  task automatic set_slice(input int idx, input logic [31:0] val);
    a_hrdata_s[idx*32 +: 32] = val;
  endtask

  initial begin
    hreset     = 1'b1;
    a_haddr    = 32'h0;
    a_htrans   = 2'b00;
    a_hready_s = 6'h3F;
    a_hresp_s  = 6'h00;
    for (int i = 0; i < 6; i++) set_slice(i, 32'h1111_1111 * (i + 1));
    b_haddr    = 32'h0;
    b_htrans   = 2'b00;
    b_hready_s = 2'b11;
    b_hresp_s  = 2'b00;
    b_hrdata_s = 64'h2222_2222_1111_1111;

    // Reset state.
    repeat (2) @(negedge hclk);
    #1;
    chk("rst_hready",   64'(a_hready),   64'd1);
    chk("rst_hresp",    64'(a_hresp),    64'd0);
    chk("rst_hrdata",   64'(a_hrdata),   64'd0);
    chk("rst_irq",      64'(a_irq),      64'd0);
    chk("rst_err_addr", 64'(a_err_addr), 64'd0);
    chk("rst_err_src",  64'(a_err_src),  64'd0);
    hreset = 1'b0;

    // Mapped read from slave 2, then a back-to-back read from the overlap region (slave 4 wins).
    @(negedge hclk);
    a_haddr = 32'h4000_0010; a_htrans = 2'b10;
    #1;
    chk("dec_s2", 64'(a_hsel), 64'(6'b000100));
    sb_q.push_back('{rdata: 32'hCAFE_F00D, resp: 1'b0});
    @(negedge hclk);
    set_slice(2, 32'hCAFE_F00D);
    a_haddr = 32'h8000_0000; a_htrans = 2'b10;
    a_hresp_s[4] = 1'b1; set_slice(4, 32'hABCD_0004);
    #1;
    chk("dec_overlap", 64'(a_hsel), 64'(6'b010000));
    sb_check("rd_s2");
    sb_q.push_back('{rdata: 32'hABCD_0004, resp: 1'b1});
    @(negedge hclk);
    a_haddr = 32'h0; a_htrans = 2'b00;
    #1;
    chk("dec_not_gated", 64'(a_hsel), 64'(6'b000001));
    sb_check("rd_s4_err");
    a_hresp_s = 6'h00;

    // Unmapped access answered by the default slave.
    @(negedge hclk);
    a_haddr = 32'hF000_0000; a_htrans = 2'b10;
    #1;
    chk("dec_unmapped", 64'(a_hsel), 64'd0);
    sb_q.push_back('{rdata: 32'h0, resp: 1'b1});
    @(negedge hclk);
    a_haddr = 32'h0; a_htrans = 2'b00;
    #1;
    chk("def_err1_hready", 64'(a_hready),   64'd0);
    chk("def_err1_hresp",  64'(a_hresp),    64'd1);
    chk("def_err_addr",    64'(a_err_addr), 64'hF000_0000);
    chk("def_err_src",     64'(a_err_src),  64'd0);
    chk("def_irq1",        64'(a_irq),      64'd0);
    @(negedge hclk);
    #1;
    chk("def_irq2", 64'(a_irq), 64'd0);
    sb_check("def_err2");
    @(negedge hclk);
    #1;
    chk("def_idle_hready", 64'(a_hready), 64'd1);
    chk("def_idle_hresp",  64'(a_hresp),  64'd0);

    // Hung slave 1: four waits, the firing cycle, then ERR1 and ERR2.
    @(negedge hclk);
    a_haddr = 32'h2000_0004; a_htrans = 2'b10;
    #1;
    chk("dec_s1", 64'(a_hsel), 64'(6'b000010));
    sb_q.push_back('{rdata: 32'h0, resp: 1'b1});
    @(negedge hclk);
    a_haddr = 32'h0; a_htrans = 2'b00; a_hready_s[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge hclk);
      #1;
      chk("hung_wait_hready", 64'(a_hready), 64'd0);
      chk("hung_wait_hresp",  64'(a_hresp),  64'd0);
      chk("hung_wait_irq",    64'(a_irq),    64'd0);
    end
    @(negedge hclk);
    a_hready_s[1] = 1'b1; set_slice(1, 32'h5555_5555);
    #1;
    chk("hung_err1_hready", 64'(a_hready),   64'd0);
    chk("hung_err1_hresp",  64'(a_hresp),    64'd1);
    chk("hung_irq",         64'(a_irq),      64'd1);
    chk("hung_err_src",     64'(a_err_src),  64'd1);
    chk("hung_err_addr",    64'(a_err_addr), 64'h2000_0004);
    @(negedge hclk);
    #1;
    chk("hung_irq_pulse", 64'(a_irq), 64'd0);
    sb_check("hung_err2");
    @(negedge hclk);
    #1;
    chk("hung_idle_hready", 64'(a_hready), 64'd1);
    chk("hung_idle_hresp",  64'(a_hresp),  64'd0);
    set_slice(1, 32'h2222_2222);

    // Write to slave 0 with one wait state, pipelined with a read from slave 3.
    @(negedge hclk);
    a_haddr = 32'h0000_0100; a_htrans = 2'b10;
    #1;
    chk("dec_s0", 64'(a_hsel), 64'(6'b000001));
    sb_q.push_back('{rdata: 32'h1111_1111, resp: 1'b0});
    @(negedge hclk);
    a_haddr = 32'h6000_0008; a_hready_s[0] = 1'b0; set_slice(3, 32'hDEAD_BEEF);
    #1;
    chk("pipe_hsel_wait", 64'(a_hsel),   64'(6'b001000));
    chk("pipe_wait",      64'(a_hready), 64'd0);
    chk("pipe_owner_s0",  64'(a_hrdata), 64'h1111_1111);
    @(negedge hclk);
    a_hready_s[0] = 1'b1;
    #1;
    chk("pipe_hsel_held", 64'(a_hsel), 64'(6'b001000));
    sb_check("wr_s0");
    sb_q.push_back('{rdata: 32'hDEAD_BEEF, resp: 1'b0});
    @(negedge hclk);
    a_haddr = 32'h0; a_htrans = 2'b00; set_slice(0, 32'h0BAD_0BAD);
    #1;
    sb_check("rd_s3");

    // Reset asserted during ERR1 of an unmapped access.
    @(negedge hclk);
    a_haddr = 32'hF100_0000; a_htrans = 2'b10;
    @(negedge hclk);
    a_haddr = 32'h0; a_htrans = 2'b00;
    #1;
    chk("rerr_err1_hready", 64'(a_hready),   64'd0);
    chk("rerr_err_addr",    64'(a_err_addr), 64'hF100_0000);
    hreset = 1'b1;
    @(negedge hclk);
    #1;
    chk("rerr_hready",   64'(a_hready),   64'd1);
    chk("rerr_hresp",    64'(a_hresp),    64'd0);
    chk("rerr_err_addr0",64'(a_err_addr), 64'd0);
    chk("rerr_err_src0", 64'(a_err_src),  64'd0);
    hreset = 1'b0;
    @(negedge hclk);
    #1;
    chk("rerr_idle_hready", 64'(a_hready), 64'd1);
    chk("rerr_idle_hresp",  64'(a_hresp),  64'd0);

    // Watchdog disabled: slave 1 of DUT B stalls for 1000 cycles.
    @(negedge hclk);
    b_haddr = 32'h2000_0000; b_htrans = 2'b10;
    #1;
    chk("b_dec_s1", 64'(b_hsel), 64'(2'b10));
    @(negedge hclk);
    b_haddr = 32'h0; b_htrans = 2'b00; b_hready_s = 2'b00;
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) @(negedge hclk);
      #1;
      chk("nowd_hready", 64'(b_hready), 64'd0);
      chk("nowd_irq",    64'(b_irq),    64'd0);
    end
    b_hready_s = 2'b11;
    #1;
    chk("nowd_release_hready", 64'(b_hready), 64'd1);
    chk("nowd_release_hresp",  64'(b_hresp),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
